// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter slice.
package rf_wb_arbiter_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_MDU = 2;

  function automatic int unsigned gid_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Generic round-robin selector: one-hot grant searching from ptr upward, ptr moves past the winner.
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int unsigned PW = gid_width(NUM_REQ);

  logic [PW-1:0] ptr_q, ptr_d;
  int unsigned   idx;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (32'(ptr_q) + off) % NUM_REQ;
      if (req[idx] && !found) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) ptr_d = PW'((i + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between NUM_REQ write-back requesters, round-robin.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned AW      = AW_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*AW-1:0]           req_rd,
  input  logic [NUM_REQ*XLEN-1:0]         req_wd,
  output logic                            rf_we,
  output logic [AW-1:0]                   rf_rd,
  output logic [XLEN-1:0]                 rf_wd,
  output logic [gid_width(NUM_REQ)-1:0]   grant_id
);

  localparam int unsigned GW = gid_width(NUM_REQ);

  logic [NUM_REQ-1:0] req_elig, gnt;
  logic               xfer;
  logic [GW-1:0]      sel;
  logic [AW-1:0]      sel_rd;
  logic [XLEN-1:0]    sel_wd;

  logic               rf_we_q, rf_we_d;
  logic [AW-1:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]    rf_wd_q, rf_wd_d;
  logic [GW-1:0]      gid_q, gid_d;

  // Masking requests (rather than the grant) keeps the pointer frozen during reset and stall.
  assign req_elig = (rst || stall) ? '0 : req_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk (clk),
    .rst (rst),
    .req (req_elig),
    .adv (xfer),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    sel    = '0;
    sel_rd = '0;
    sel_wd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel    = GW'(i);
        sel_rd = req_rd[i*AW +: AW];
        sel_wd = req_wd[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    rf_we_d = 1'b0;
    rf_rd_d = rf_rd_q;
    rf_wd_d = rf_wd_q;
    gid_d   = gid_q;
    if (xfer) begin
      rf_we_d = (sel_rd != '0);
      rf_rd_d = sel_rd;
      rf_wd_d = sel_wd;
      gid_d   = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q <= 1'b0;
      rf_rd_q <= '0;
      rf_wd_q <= '0;
      gid_q   <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      rf_rd_q <= rf_rd_d;
      rf_wd_q <= rf_wd_d;
      gid_q   <= gid_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wd    = rf_wd_q;
  assign grant_id = gid_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected rf_* pushed at drive time, popped after the edge.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int XL = 32;

  logic            clk = 1'b0;
  logic            rst, stall;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*AW-1:0] req_rd;
  logic [N*XL-1:0] req_wd;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XL-1:0]   rf_wd;
  logic [1:0]      grant_id;

  rf_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_wd    (req_wd),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [XL-1:0] wd;
    logic [1:0]    gid;
  } out_t;

  out_t sbq[$];
  out_t mo;
  int   mptr = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XL-1:0] wd);
    req_rd[i*AW +: AW] = rd;
    req_wd[i*XL +: XL] = wd;
  endtask

  // One cycle: check ready, push expected output, clock, pop and compare.
  task automatic step(output int g);
    out_t e;
    #1;
    g = (rst || stall) ? -1 : model_grant(req_valid, mptr);
    check_val("ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    if (rst) begin
      mo   = '0;
      mptr = 0;
    end else begin
      mo.we = 1'b0;
      if (g >= 0) begin
        mo.rd  = req_rd[g*AW +: AW];
        mo.wd  = req_wd[g*XL +: XL];
        mo.we  = (mo.rd != 0);
        mo.gid = 2'(g);
        mptr   = (g + 1) % N;
      end
    end
    sbq.push_back(mo);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_val("rf_we", 64'(rf_we), 64'(e.we));
    check_val("rf_rd", 64'(rf_rd), 64'(e.rd));
    check_val("rf_wd", 64'(rf_wd), 64'(e.wd));
    check_val("grant_id", 64'(grant_id), 64'(e.gid));
  endtask

  task automatic tick();
    int g;
    step(g);
  endtask

  task automatic reset_cycle();
    req_valid = '0;
    stall     = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Requester hold rule: an ungranted valid keeps valid, rd and wd stable.
  logic [N-1:0]    pv = '0, pr = '0;
  logic [N*AW-1:0] prd = '0;
  logic [N*XL-1:0] pwd = '0;
  logic            prst = 1'b1;

  always @(posedge clk) begin
    if (!rst && !prst) begin
      for (int i = 0; i < N; i++) begin
        if (pv[i] && !pr[i])
          assert (req_valid[i] && req_rd[i*AW +: AW] == prd[i*AW +: AW] &&
                  req_wd[i*XL +: XL] == pwd[i*XL +: XL])
          else $error("requester %0d dropped or changed an ungranted request", i);
      end
    end
    pv   <= req_valid;
    pr   <= req_ready;
    prd  <= req_rd;
    pwd  <= req_wd;
    prst <= rst;
  end

  initial begin
    int g, k, w;
    logic got;
    rst = 1'b1; stall = 1'b0; req_valid = '0; req_rd = '0; req_wd = '0;

    // reset state
    tick(); tick();
    check_val("rst_we", 64'(rf_we), 64'd0);
    check_val("rst_gid", 64'(grant_id), 64'd0);
    rst = 1'b0;
    tick();

    // single requester
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    step(g);
    check_val("single_we", 64'(rf_we), 64'd1);
    check_val("single_rd", 64'(rf_rd), 64'd5);
    check_val("single_wd", 64'(rf_wd), 64'hDEADBEEF);
    check_val("single_gid", 64'(grant_id), 64'd0);
    req_valid = '0;
    step(g);
    check_val("single_we_off", 64'(rf_we), 64'd0);

    // contention: strict rotation, no gaps
    reset_cycle();
    set_req(0, 5'd1, 32'hA0); set_req(1, 5'd2, 32'hA1); set_req(2, 5'd3, 32'hA2);
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step(g);
      check_val("cont_gid", 64'(grant_id), 64'(i % 3));
      check_val("cont_rd", 64'(rf_rd), 64'(i % 3 + 1));
      check_val("cont_we", 64'(rf_we), 64'd1);
    end

    // x0 write consumed, no strobe, ptr still advances
    reset_cycle();
    set_req(1, 5'd0, 32'h1234);
    req_valid = 3'b010;
    step(g);
    check_val("x0_we", 64'(rf_we), 64'd0);
    check_val("x0_gid", 64'(grant_id), 64'd1);
    check_val("x0_wd", 64'(rf_wd), 64'h1234);
    set_req(2, 5'd9, 32'hB2);
    req_valid = 3'b110;
    step(g);
    check_val("x0_ptr", 64'(grant_id), 64'd2);
    req_valid = 3'b010;
    step(g);
    check_val("x0_again", 64'(grant_id), 64'd1);
    req_valid = '0;
    tick();

    // stall blocks grants, ptr holds
    reset_cycle();
    set_req(1, 5'd4, 32'hC1); set_req(2, 5'd6, 32'hC2);
    req_valid = 3'b110;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(g);
      check_val("stall_we", 64'(rf_we), 64'd0);
    end
    stall = 1'b0;
    step(g);
    check_val("unstall_gid1", 64'(grant_id), 64'd1);
    req_valid = 3'b100;
    step(g);
    check_val("unstall_gid2", 64'(grant_id), 64'd2);

    // write already in output stage survives stall rising
    set_req(0, 5'd8, 32'hC0);
    req_valid = 3'b001;
    step(g);
    stall = 1'b1;
    req_valid = '0;
    check_val("inflight_we", 64'(rf_we), 64'd1);
    step(g);
    check_val("inflight_done", 64'(rf_we), 64'd0);
    check_val("inflight_hold", 64'(rf_rd), 64'd8);

    // reset dominates stall
    req_valid = 3'b111;
    rst = 1'b1;
    step(g);
    check_val("rststall_rd", 64'(rf_rd), 64'd0);
    rst = 1'b0; stall = 1'b0; req_valid = '0;
    tick();

    // reset mid-operation drops the in-flight write
    set_req(2, 5'd7, 32'hE7);
    req_valid = 3'b100;
    step(g);
    check_val("mid_we_pre", 64'(rf_we), 64'd1);
    check_val("mid_rd_pre", 64'(rf_rd), 64'd7);
    set_req(0, 5'd10, 32'hE0);
    req_valid = 3'b101;
    rst = 1'b1;
    step(g);
    check_val("mid_we_rst", 64'(rf_we), 64'd0);
    rst = 1'b0;
    step(g);
    check_val("mid_first", 64'(grant_id), 64'd0);
    req_valid = 3'b100;
    step(g);
    check_val("mid_second", 64'(grant_id), 64'd2);

    // ptr returns to 0 after reset even when it was elsewhere
    req_valid = 3'b001;
    step(g);
    req_valid = 3'b101;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    step(g);
    check_val("rst_ptr", 64'(grant_id), 64'd0);
    req_valid = 3'b100;
    tick();

    // fairness: requester 2 joins a permanently valid requester 0
    reset_cycle();
    set_req(0, 5'd11, 32'hF0); set_req(2, 5'd12, 32'hF2);
    req_valid = 3'b001;
    k = $urandom_range(1, 5);
    for (int i = 0; i < k; i++) tick();
    req_valid = 3'b101;
    w = 0; got = 1'b0;
    while (!got && w < 4) begin
      step(g);
      w++;
      if (rf_we && grant_id == 2'd2) got = 1'b1;
    end
    check_val("fair_latency", 64'(got && w <= 2), 64'd1);
    reset_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
